smac_ctrl: RTL and testbench

SMAC_CTRL -- requirements
Module: smac_ctrl

---
 rtl/smac_pkg.sv | 24 ++
 rtl/smac_ctrl_cnt.sv | 27 ++
 rtl/smac_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_smac_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/smac_pkg.sv
// Shared types and constants for the smac job controller.
// FSM state encoding, precision one-hot codes and default pipeline depth.
package smac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] PREC_INT8  = 4'b0001;
  localparam logic [3:0] PREC_INT16 = 4'b0010;
  localparam logic [3:0] PREC_INT32 = 4'b0100;
  localparam logic [3:0] PREC_INT64 = 4'b1000;

  localparam int MAC_LAT_DEF = 3;

  function automatic logic is_onehot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/smac_ctrl_cnt.sv
// Loadable down-counter shared by the beat and drain phases.
// Load has priority over decrement; zero flags an empty job length.
module smac_ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/smac_ctrl.sv
// Job sequencer for an smac pipeline: clear, stream beats, drain, report.
// Optional SMAC_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module smac_ctrl
  import smac_pkg::*;
#(
  parameter int MAC_LATENCY = MAC_LAT_DEF,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [3:0]       cfg_prec,
  input  logic [1:0]       cfg_fp,
  input  logic             cfg_chain,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             smac_ce,
  output logic             smac_sclr,
  output logic             smac_active_chain,
  output logic [3:0]       smac_select_precision,
  output logic [1:0]       smac_enable_fp_unit,
  output logic             op_zero,
  output logic             busy,
  output logic             cfg_err
`ifdef SMAC_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_busy,
  output logic [31:0]      perf_stall
`endif
);

  localparam logic [LEN_W-1:0] LAT = LEN_W'(MAC_LATENCY);

  state_t           state;
  state_t           nxt;
  logic             cnt_ld;
  logic             cnt_dec;
  logic [LEN_W-1:0] cnt_val;
  logic [LEN_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_last;
  logic             accept;

  smac_ctrl_cnt #(
    .W(LEN_W)
  ) u_cnt (
    .clk (clk),
    .srst(srst),
    .ld  (cnt_ld),
    .dec (cnt_dec),
    .val (cnt_val),
    .cnt (cnt),
    .zero(cnt_zero)
  );

  assign cnt_last = (cnt == LEN_W'(1));
  assign accept   = cfg_valid && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Counter holds beats left in RUN, then cycles left in DRAIN.
  always_comb begin
    nxt     = state;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = cfg_len;
    unique case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          nxt    = S_CLEAR;
          cnt_ld = 1'b1;
        end
      end
      S_CLEAR: begin
        if (cnt_zero) begin
          nxt     = S_DRAIN;
          cnt_ld  = 1'b1;
          cnt_val = LAT;
        end else begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (op_valid) begin
          if (cnt_last) begin
            nxt     = S_DRAIN;
            cnt_ld  = 1'b1;
            cnt_val = LAT;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    smac_ce   = 1'b0;
    smac_sclr = 1'b0;
    op_zero   = 1'b0;
    unique case (state)
      S_IDLE:  cfg_ready = 1'b1;
      S_CLEAR: begin
        smac_sclr = 1'b1;
        smac_ce   = 1'b1;
      end
      S_RUN: begin
        op_ready = 1'b1;
        smac_ce  = op_valid;
      end
      S_DRAIN: begin
        smac_ce = 1'b1;
        op_zero = 1'b1;
      end
      S_DONE:  res_valid = 1'b1;
      default: cfg_ready = 1'b0;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Illegal precision falls back to INT8 so the pipeline stays defined.
  always_ff @(posedge clk) begin
    if (srst) begin
      smac_select_precision <= '0;
      smac_enable_fp_unit   <= '0;
      smac_active_chain     <= 1'b0;
      cfg_err               <= 1'b0;
    end else begin
      cfg_err <= accept && !is_onehot(cfg_prec);
      if (accept) begin
        smac_select_precision <= is_onehot(cfg_prec) ? cfg_prec : PREC_INT8;
        smac_enable_fp_unit   <= cfg_fp;
        smac_active_chain     <= cfg_chain;
      end
    end
  end

`ifdef SMAC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && (perf_busy != '1)) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if ((state == S_RUN) && !op_valid && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_smac_ctrl.sv
// Directed bench for smac_ctrl: latency, stalls, empty and max jobs,
// precision coercion, mid-job reset and result back-pressure.
module tb_smac_ctrl;

  localparam int LAT = 3;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          srst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_len;
  logic [3:0]    cfg_prec;
  logic [1:0]    cfg_fp;
  logic          cfg_chain;
  logic          op_valid;
  logic          op_ready;
  logic          res_valid;
  logic          res_ready;
  logic          smac_ce;
  logic          smac_sclr;
  logic          smac_active_chain;
  logic [3:0]    smac_select_precision;
  logic [1:0]    smac_enable_fp_unit;
  logic          op_zero;
  logic          busy;
  logic          cfg_err;
`ifdef SMAC_CTRL_PERF_EN
  logic [31:0]   perf_busy;
  logic [31:0]   perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  smac_ctrl #(
    .MAC_LATENCY(LAT),
    .LEN_W      (LW)
  ) dut (
    .clk                  (clk),
    .srst                 (srst),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_len              (cfg_len),
    .cfg_prec             (cfg_prec),
    .cfg_fp               (cfg_fp),
    .cfg_chain            (cfg_chain),
    .op_valid             (op_valid),
    .op_ready             (op_ready),
    .res_valid            (res_valid),
    .res_ready            (res_ready),
    .smac_ce              (smac_ce),
    .smac_sclr            (smac_sclr),
    .smac_active_chain    (smac_active_chain),
    .smac_select_precision(smac_select_precision),
    .smac_enable_fp_unit  (smac_enable_fp_unit),
    .op_zero              (op_zero),
    .busy                 (busy),
    .cfg_err              (cfg_err)
`ifdef SMAC_CTRL_PERF_EN
    ,
    .perf_busy            (perf_busy),
    .perf_stall           (perf_stall)
`endif
  );

  logic [13:0] outs;
  assign outs = {res_valid, op_ready, smac_ce, smac_sclr,
                 smac_active_chain, smac_select_precision,
                 smac_enable_fp_unit, op_zero, busy, cfg_err};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string tag, input int len,
                         input logic [3:0] prec, input logic [1:0] fp,
                         input logic chain, input int gap_n,
                         input int hold_n, input int exp_lat,
                         input logic [3:0] exp_prec, input int exp_err);
    int n, beats, gap, ce_n, sclr_n, oz_n, ordy_n, err_n, gap_ce, hold_ok;
    logic done;
    n = 1; beats = 0; gap = gap_n; ce_n = 0; sclr_n = 0; oz_n = 0;
    ordy_n = 0; err_n = 0; gap_ce = 0; hold_ok = 0; done = 1'b0;
    cfg_len   = LW'(len);
    cfg_prec  = prec;
    cfg_fp    = fp;
    cfg_chain = chain;
    cfg_valid = 1'b1;
    op_valid  = 1'b0;
    res_ready = (hold_n == 0);
    #1;
    chk({tag, ":cfg_ready"}, 32'(cfg_ready), 32'd1);
    tick;
    cfg_valid = 1'b0;
    while (!done && n <= exp_lat + 20) begin
      if (beats == 2 && gap > 0 && op_ready) begin
        op_valid = 1'b0;
        gap--;
      end else begin
        op_valid = 1'b1;
      end
      #1;
      if (n == 1) begin
        chk({tag, ":clear"}, {30'd0, smac_sclr, smac_ce}, 32'd3);
        chk({tag, ":prec"}, 32'(smac_select_precision), 32'(exp_prec));
        chk({tag, ":fp_chain"}, {29'd0, smac_enable_fp_unit, smac_active_chain},
            {29'd0, fp, chain});
      end
      ce_n   += int'(smac_ce);
      sclr_n += int'(smac_sclr);
      oz_n   += int'(op_zero);
      ordy_n += int'(op_ready);
      err_n  += int'(cfg_err);
      if (op_ready && !op_valid && smac_ce) gap_ce++;
      if (op_ready && op_valid) beats++;
      if (res_valid) begin
        done = 1'b1;
      end else begin
        tick;
        n++;
      end
    end
    chk({tag, ":latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ":ce_cycles"}, 32'(ce_n), 32'(1 + len + LAT));
    chk({tag, ":sclr_cycles"}, 32'(sclr_n), 32'd1);
    chk({tag, ":drain_cycles"}, 32'(oz_n), 32'(LAT));
    chk({tag, ":op_ready_cycles"}, 32'(ordy_n), 32'(len + gap_n));
    chk({tag, ":beats"}, 32'(beats), 32'(len));
    chk({tag, ":gap_ce"}, 32'(gap_ce), 32'd0);
    chk({tag, ":err_pulses"}, 32'(err_n), 32'(exp_err));
    chk({tag, ":done_prec"}, 32'(smac_select_precision), 32'(exp_prec));
    op_valid = 1'b0;
    if (hold_n > 0) begin
      for (int i = 0; i < hold_n; i++) begin
        if (res_valid && !cfg_ready && busy) hold_ok++;
        tick;
      end
      chk({tag, ":hold"}, 32'(hold_ok), 32'(hold_n));
      res_ready = 1'b1;
      #1;
      chk({tag, ":res_valid_after_hold"}, 32'(res_valid), 32'd1);
    end
    tick;
    chk({tag, ":idle"}, {30'd0, busy, cfg_ready}, 32'd1);
  endtask

  initial begin
    srst      = 1'b1;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    cfg_prec  = '0;
    cfg_fp    = '0;
    cfg_chain = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    tick;
    tick;
    srst = 1'b0;
    chk("reset:outs", 32'(outs), 32'd0);
    chk("reset:cfg_ready", 32'(cfg_ready), 32'd1);

    run_job("basic", 4, 4'b0010, 2'b01, 1'b1, 0, 0, 9, 4'b0010, 0);
    run_job("stall", 4, 4'b0100, 2'b10, 1'b0, 2, 0, 11, 4'b0100, 0);
    run_job("empty", 0, 4'b1000, 2'b00, 1'b0, 0, 0, 5, 4'b1000, 0);
    run_job("badprec", 2, 4'b0011, 2'b11, 1'b1, 0, 0, 7, 4'b0001, 1);
    run_job("backpr", 3, 4'b0001, 2'b00, 1'b1, 0, 5, 8, 4'b0001, 0);

    cfg_len   = LW'(4);
    cfg_prec  = 4'b0010;
    cfg_fp    = 2'b01;
    cfg_chain = 1'b1;
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    op_valid  = 1'b1;
    tick;
    tick;
    srst = 1'b1;
    tick;
    srst     = 1'b0;
    op_valid = 1'b0;
    chk("midrst:outs", 32'(outs), 32'd0);
    chk("midrst:cfg_ready", 32'(cfg_ready), 32'd1);
    run_job("post_rst", 4, 4'b0010, 2'b00, 1'b0, 0, 0, 9, 4'b0010, 0);

    run_job("maxlen", 65535, 4'b0100, 2'b00, 1'b0, 0, 0,
            2 + 65535 + LAT, 4'b0100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
